// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between two writeback
//   requesters (port 0 = ALU result, port 1 = load data). Each requester
//   has its own DEPTH-entry FIFO. A round-robin arbiter drains one entry
//   per clock onto registered we/rd/dataIn. Those outputs are therefore
//   stable when the register file writes on the falling edge.
//
// Parameters
//   DEPTH  : entries per requester FIFO (power of two, >= 2)
//   DATA_W : write data width
//   ADDR_W : register address width
//
// Ports
//   clk, rst             : clock, asynchronous active-low reset
//   pN_valid/pN_ready    : per-port push handshake (ready = FIFO not full)
//   pN_rd/pN_data        : per-port destination register and data
//   we/rd/dataIn         : register-file write port (registered)
//   q_rs/q_rt            : hazard query addresses from decode
//   hit_rs/hit_rt        : a write to the queried register is pending
//   busy                 : a FIFO holds an entry, or we is high
//
// Build option
//   RF_WB_DROP_R0_EN : when defined, entries that target register 0 are
//                      popped and use their grant slot, but no write is
//                      issued (we stays low and rd/dataIn hold).

module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_rd,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_rd,
  input  logic [DATA_W-1:0] p1_data,
  output logic              we,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] q_rs,
  input  logic [ADDR_W-1:0] q_rt,
  output logic              hit_rs,
  output logic              hit_rt,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Index 0 is the ALU port and index 1 is the load port.
  entry_t            mem [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [2];
  logic [PTR_W-1:0]  rd_ptr [2];
  logic [CNT_W-1:0]  cnt [2];
  logic              last_grant;

  logic              in_valid [2];
  entry_t            in_ent [2];
  logic [1:0]        full, nonempty, push, pop;
  logic              any_ne;
  logic              grant_port;
  entry_t            head;

  assign in_valid[0] = p0_valid;
  assign in_valid[1] = p1_valid;
  assign in_ent[0]   = '{rd: p0_rd, data: p0_data};
  assign in_ent[1]   = '{rd: p1_rd, data: p1_data};

  // Push and pop decisions. Both use only registered state. A full FIFO
  // therefore refuses a push even in a cycle where it also pops, and an
  // empty FIFO cannot issue the entry being pushed into it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    push       = '0;
    pop        = '0;
    grant_port = 1'b0;
    for (int i = 0; i < 2; i++) begin
      full[i]     = (cnt[i] == CNT_W'(DEPTH));
      nonempty[i] = (cnt[i] != '0);
      push[i]     = in_valid[i] && rst && !full[i];
    end
    any_ne = |nonempty;
    // Round robin applies only when both ports have work. Otherwise the
    // only non-empty port wins.
    if (nonempty[0] && nonempty[1]) grant_port = ~last_grant;
    else                            grant_port = nonempty[1];
    if (any_ne) pop[grant_port] = 1'b1;
    head = mem[grant_port][rd_ptr[grant_port]];
  end

  assign p0_ready = rst && !full[0];
  assign p1_ready = rst && !full[1];
  assign busy     = any_ne || we;

  // NOTE: FIFO storage has no reset. Pointers and counts define which entries are live, so stale data is never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_ent[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      last_grant <= 1'b1;
      we         <= 1'b0;
      rd         <= '0;
      dataIn     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        unique case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end

      if (any_ne) begin
        last_grant <= grant_port;
`ifdef RF_WB_DROP_R0_EN
        // Register 0 is hardwired to zero. The slot is consumed, but no
        // write is issued.
        if (head.rd != '0) begin
          we     <= 1'b1;
          rd     <= head.rd;
          dataIn <= head.data;
        end else begin
          we     <= 1'b0;
        end
`else
        we     <= 1'b1;
        rd     <= head.rd;
        dataIn <= head.data;
`endif
      end else begin
        we <= 1'b0;
      end
    end
  end

  // Hazard query. An entry is live when its distance from the read
  // pointer, taken modulo DEPTH, is below the count. The write being
  // presented this cycle (we=1) also counts as pending. Address 0 never
  // hits.
  always_comb begin
    logic [PTR_W-1:0] off;
    off    = '0;
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        off = PTR_W'(j) - rd_ptr[i];
        if (CNT_W'(off) < cnt[i]) begin
          if (mem[i][j].rd == q_rs) hit_rs = 1'b1;
          if (mem[i][j].rd == q_rt) hit_rt = 1'b1;
        end
      end
    end
    if (we && rd == q_rs) hit_rs = 1'b1;
    if (we && rd == q_rt) hit_rt = 1'b1;
    if (q_rs == '0) hit_rs = 1'b0;
    if (q_rt == '0) hit_rt = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. Directed scenarios and a randomized
// phase are checked against a queue-based reference model. The model
// tracks pending writes per port, the last grant, and the expected write
// port.

module tb_regfile_wb_arbiter;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              p0_valid = 1'b0, p1_valid = 1'b0;
  logic              p0_ready, p1_ready;
  logic [ADDR_W-1:0] p0_rd = '0, p1_rd = '0;
  logic [DATA_W-1:0] p0_data = '0, p1_data = '0;
  logic              we;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] dataIn;
  logic [ADDR_W-1:0] q_rs = '0, q_rt = '0;
  logic              hit_rs, hit_rt, busy;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rd(p0_rd), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rd(p1_rd), .p1_data(p1_data),
    .we(we), .rd(rd), .dataIn(dataIn),
    .q_rs(q_rs), .q_rt(q_rt), .hit_rs(hit_rs), .hit_rt(hit_rt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model.
  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              mq0[$], mq1[$];
  int                m_last = 1;
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_rd = '0;
  logic [DATA_W-1:0] m_data = '0;

  logic [ADDR_W-1:0] issued[$];
  int                cyc = 0;
  int                issue_cyc[$];
  bit                last_acc0, last_acc1, saw_full;

  function automatic bit m_hit(input logic [ADDR_W-1:0] a);
    if (a == 0) return 1'b0;
    foreach (mq0[k]) if (mq0[k].rd == a) return 1'b1;
    foreach (mq1[k]) if (mq1[k].rd == a) return 1'b1;
    return m_we && (m_rd == a);
  endfunction

  function automatic void model_clear();
    mq0.delete();
    mq1.delete();
    m_last = 1;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endfunction

  // One clock. Check combinational outputs before the edge, advance the
  // model, then check registered outputs at the next falling edge.
  // Inputs are changed only between steps, at the falling edge.
  task automatic step();
    ent_t e;
    int   g;
    #1;
    check("p0_ready", p0_ready, mq0.size() < DEPTH);
    check("p1_ready", p1_ready, mq1.size() < DEPTH);
    check("hit_rs",   hit_rs,   m_hit(q_rs));
    check("hit_rt",   hit_rt,   m_hit(q_rt));
    check("busy",     busy,     (mq0.size() != 0) || (mq1.size() != 0) || m_we);
    last_acc0 = p0_valid && (mq0.size() < DEPTH);
    last_acc1 = p1_valid && (mq1.size() < DEPTH);
    if (p0_valid && !p0_ready) saw_full = 1'b1;
    @(posedge clk);
    g = -1;
    if (mq0.size() != 0 && mq1.size() != 0) g = (m_last == 1) ? 0 : 1;
    else if (mq0.size() != 0)               g = 0;
    else if (mq1.size() != 0)               g = 1;
    if (g >= 0) begin
      if (g == 0) e = mq0.pop_front();
      else        e = mq1.pop_front();
      m_last = g;
`ifdef RF_WB_DROP_R0_EN
      if (e.rd == 0) m_we = 1'b0;
      else begin
        m_we = 1'b1; m_rd = e.rd; m_data = e.data;
      end
`else
      m_we = 1'b1; m_rd = e.rd; m_data = e.data;
`endif
    end else begin
      m_we = 1'b0;
    end
    if (last_acc0) mq0.push_back('{rd: p0_rd, data: p0_data});
    if (last_acc1) mq1.push_back('{rd: p1_rd, data: p1_data});
    @(negedge clk);
    cyc++;
    check("we",     we,     m_we);
    check("rd",     rd,     m_rd);
    check("dataIn", dataIn, m_data);
    if (we) begin
      issued.push_back(rd);
      issue_cyc.push_back(cyc);
    end
  endtask

  task automatic idle_inputs();
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    q_rs     = '0;
    q_rt     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_rel_ready", p0_ready, 1'b1);
    check("rst_rel_busy",  busy,     1'b0);
  endtask

  localparam logic [ADDR_W-1:0] EXP_ORDER [8] = '{1, 17, 2, 18, 3, 19, 4, 20};

  initial begin
    int i0, i1;

    // Reset held with a request present: nothing is accepted.
    rst      = 1'b0;
    p0_valid = 1'b1;
    p0_rd    = 5'd3;
    p0_data  = 32'h1111_1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p0_ready", p0_ready, 1'b0);
    check("rst_p1_ready", p1_ready, 1'b0);
    check("rst_we",       we,       1'b0);
    check("rst_rd",       rd,       '0);
    check("rst_busy",     busy,     1'b0);
    p0_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rel_p0_ready", p0_ready, 1'b1);
    check("rel_p1_ready", p1_ready, 1'b1);
    check("rel_busy",     busy,     1'b0);

    // Single write: an entry pushed at edge k is written at edge k+1, for one cycle.
    do_reset();
    p0_valid = 1'b1; p0_rd = 5'd5; p0_data = 32'hDEAD_BEEF;
    step();
    p0_valid = 1'b0;
    check("sw_k_we", we, 1'b0);
    step();
    check("sw_we",     we,     1'b1);
    check("sw_rd",     rd,     5'd5);
    check("sw_dataIn", dataIn, 32'hDEAD_BEEF);
    step();
    check("sw_we_off", we, 1'b0);

    // Contention: strict alternation, with no idle cycle between writes.
    do_reset();
    issued.delete();
    issue_cyc.delete();
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 14; c++) begin
      p0_valid = (i0 < 4); p0_rd = ADDR_W'(1 + i0);  p0_data = $urandom;
      p1_valid = (i1 < 4); p1_rd = ADDR_W'(17 + i1); p1_data = $urandom;
      step();
      if (last_acc0) i0++;
      if (last_acc1) i1++;
    end
    idle_inputs();
    check("ct_count", issued.size(), 8);
    for (int k = 0; k < 8 && k < issued.size(); k++)
      check($sformatf("ct_order%0d", k), issued[k], EXP_ORDER[k]);
    if (issue_cyc.size() == 8)
      check("ct_no_idle", issue_cyc[7] - issue_cyc[0], 7);

    // Full FIFO: port 1 traffic holds the drain back, so port 0 fills.
    do_reset();
    saw_full = 1'b0;
    for (int c = 0; c < 8; c++) begin
      p0_valid = 1'b1; p0_rd = ADDR_W'(c + 1);  p0_data = $urandom;
      p1_valid = 1'b1; p1_rd = ADDR_W'(c + 16); p1_data = $urandom;
      step();
    end
    idle_inputs();
    check("full_seen", saw_full, 1'b1);
    step();
    check("full_recover", p0_ready, 1'b1);
    repeat (6) step();

    // Hazard query.
    do_reset();
    p1_valid = 1'b1; p1_rd = 5'd9; p1_data = 32'h99; q_rs = 5'd9;
    step();
    p1_valid = 1'b0;
    #1;
    check("hz_fifo", hit_rs, 1'b1);
    step();
    check("hz_we",   hit_rs, 1'b1);
    step();
    check("hz_fall", hit_rs, 1'b0);
    q_rs = '0;
    p0_valid = 1'b1; p0_rd = '0; p0_data = 32'h5;
    step();
    p0_valid = 1'b0;
    #1;
    check("hz_r0", hit_rs, 1'b0);
    repeat (2) step();

    // Entries that target register 0.
    do_reset();
    p0_valid = 1'b1; p0_rd = '0; p0_data = 32'h1234;
    step();
    p0_valid = 1'b0;
    check("r0_busy_q", busy, 1'b1);
    step();
`ifdef RF_WB_DROP_R0_EN
    check("r0_we",   we,   1'b0);
    check("r0_busy", busy, 1'b0);
`else
    check("r0_we",     we,     1'b1);
    check("r0_rd",     rd,     '0);
    check("r0_dataIn", dataIn, 32'h1234);
`endif
    step();
    check("r0_idle_we",   we,   1'b0);
    check("r0_idle_busy", busy, 1'b0);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      p0_valid = ($urandom_range(0, 9) < 6);
      p1_valid = ($urandom_range(0, 9) < 6);
      p0_rd    = ADDR_W'($urandom_range(0, 7));
      p1_rd    = ADDR_W'($urandom_range(0, 7));
      p0_data  = $urandom;
      p1_data  = $urandom;
      q_rs     = ADDR_W'($urandom_range(0, 7));
      q_rt     = ADDR_W'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
